// File: rtl/tdc_pkg.sv
// Shared constants for the fine-time classifier: register offsets, hit-entry
// field layout and the fine-time width helper.
package tdc_pkg;

  localparam int OFS_CFG        = 0;
  localparam int OFS_WIN0       = 1;
  localparam int CFG_RECORD_ALL = 31;
  localparam int TS_W           = 16;
  localparam int ENTRY_FT_LSB   = 0;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_CFG,
    REG_WIN,
    REG_STATUS,
    REG_FIFO
  } reg_sel_e;

  function automatic int OFS_STATUS(input int nclass);
    return nclass + 1;
  endfunction

  function automatic int OFS_FIFO(input int nclass);
    return nclass + 2;
  endfunction

  function automatic int ft_width(input int taps);
    return $clog2(taps);
  endfunction

  // Entry layout, LSB first: fine_time, class_hit, multi_hit, coarse_ts.
  function automatic int entry_cls_lsb(input int ft_w);
    return ft_w;
  endfunction

  function automatic int entry_mh_pos(input int ft_w, input int nclass);
    return ft_w + nclass;
  endfunction

  function automatic int entry_ts_lsb(input int ft_w, input int nclass);
    return ft_w + nclass + 1;
  endfunction

endpackage

// File: rtl/fine_time_classifier_if.sv
// Local-bus bundle of the fine-time classifier; the block is the slave.
interface fine_time_classifier_if;
  logic [7:0]  Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        Read;
  logic        Write;
  logic        ack;

  modport master (output Address, DataIn, Read, Write, input DataOut, ack);
  modport slave  (input Address, DataIn, Read, Write, output DataOut, ack);
endinterface

// File: rtl/hit_fifo.sv
// Synchronous hit FIFO with fill count; a push into a full FIFO succeeds only
// when a pop happens in the same cycle.
module hit_fifo #(
  parameter  int DEPTH = 16,
  parameter  int W     = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   fill_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_q];
  assign fill_o  = cnt_q;

  // NOTE: storage has no reset; only the pointers and count define which words are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/fine_time_classifier.sv
// Two-stage fine-time decoder and classifier with timestamped hit FIFO and
// local-bus register file. Define FINE_TIME_LOOSE_EDGE_EN for the relaxed edge pattern.
module fine_time_classifier
  import tdc_pkg::*;
#(
  parameter  int                    TAPS       = 32,
  parameter  int                    NCLASS     = 3,
  parameter  logic [7:0]            BASE_ADDR  = 8'h00,
  parameter  int                    FIFO_DEPTH = 16,
  parameter  logic [NCLASS*32-1:0]  WIN_RST    = {32'h0F000000, 32'h0000F000, 32'hFFFFFFFF},
  localparam int                    FT_W       = ft_width(TAPS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [TAPS+3:0]     sample_in,
  input  logic                sample_vld,
  output logic [NCLASS-1:0]   class_hit,
  output logic [FT_W-1:0]     fine_time,
  output logic                multi_hit,
  output logic                hit_vld,
  fine_time_classifier_if.slave bus
);

  localparam int FILL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int CLS_LSB = entry_cls_lsb(FT_W);
  localparam int MH_POS  = entry_mh_pos(FT_W, NCLASS);
  localparam int TS_LSB  = entry_ts_lsb(FT_W, NCLASS);

  logic [TS_W-1:0]   coarse_q, ts1_q, ts2_q;
  logic [TAPS-1:0]   edges_d, edges_q;
  logic [FT_W-1:0]   ft_d, ft_q;
  logic              multi_d, multi_q, hit_q;
  logic [NCLASS-1:0] class_d, class_q;
  logic [31:0]       cfg_q;
  logic [31:0]       win_q [NCLASS];
  logic              ovf_q;
  logic [7:0]        drop_q;
  logic [31:0]       dout_q;
  logic              ack_q;

  logic unused_taps;
  assign unused_taps = ^sample_in[2:0];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    edges_d = '0;
    if (sample_vld) begin
      for (int k = 0; k < TAPS; k++) begin
`ifdef FINE_TIME_LOOSE_EDGE_EN
        edges_d[k] = sample_in[k+3] & ~sample_in[k+4];
`else
        edges_d[k] = sample_in[k+1] & sample_in[k+2] & sample_in[k+3] & ~sample_in[k+4];
`endif
      end
    end
  end

  // Lowest edge wins: scan downwards so the last assignment is the smallest index.
  always_comb begin
    ft_d    = '0;
    class_d = '0;
    for (int k = TAPS - 1; k >= 0; k--) begin
      if (edges_q[k]) ft_d = FT_W'(k);
    end
    multi_d = |(edges_q & (edges_q - TAPS'(1)));
    for (int c = 0; c < NCLASS; c++) begin
      class_d[c] = (|(edges_q & win_q[c][TAPS-1:0])) & cfg_q[c];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      coarse_q <= '0;
      edges_q  <= '0;
      ts1_q    <= '0;
      ts2_q    <= '0;
      hit_q    <= 1'b0;
      ft_q     <= '0;
      multi_q  <= 1'b0;
      class_q  <= '0;
    end else begin
      coarse_q <= coarse_q + TS_W'(1);
      edges_q  <= edges_d;
      ts1_q    <= coarse_q;
      ts2_q    <= ts1_q;
      hit_q    <= |edges_q;
      ft_q     <= ft_d;
      multi_q  <= multi_d;
      class_q  <= class_d;
    end
  end

  assign hit_vld   = hit_q;
  assign fine_time = ft_q;
  assign multi_hit = multi_q;
  assign class_hit = class_q;

  logic              push, pop, drop;
  logic              fifo_full, fifo_empty;
  logic [31:0]       entry, fifo_rdata;
  logic [FILL_W-1:0] fill;

  always_comb begin
    entry = '0;
    entry[ENTRY_FT_LSB +: FT_W] = ft_q;
    entry[CLS_LSB +: NCLASS]    = class_q;
    entry[MH_POS]               = multi_q;
    entry[TS_LSB +: TS_W]       = ts2_q;
  end

  assign push = (|class_q) | (cfg_q[CFG_RECORD_ALL] & hit_q);
  assign drop = push & fifo_full & ~pop;

  hit_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (entry),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .fill_o  (fill)
  );

  logic [7:0]  ofs;
  reg_sel_e    sel;
  logic        wr_en, rd_en;
  logic [31:0] win_rd, status_w, rdata_d;

  assign ofs = bus.Address - BASE_ADDR;

  always_comb begin
    sel = REG_NONE;
    if (ofs == 8'(OFS_CFG))                                sel = REG_CFG;
    else if (ofs >= 8'(OFS_WIN0) && ofs <= 8'(NCLASS))     sel = REG_WIN;
    else if (ofs == 8'(OFS_STATUS(NCLASS)))                sel = REG_STATUS;
    else if (ofs == 8'(OFS_FIFO(NCLASS)))                  sel = REG_FIFO;
  end

  always_comb begin
    win_rd = '0;
    for (int c = 0; c < NCLASS; c++) begin
      if (ofs == 8'(OFS_WIN0 + c)) win_rd = win_q[c];
    end
  end

  // A simultaneous Write takes the cycle, so a FIFO read only pops when Write is low.
  assign wr_en    = bus.Write & (sel != REG_NONE);
  assign rd_en    = bus.Read & ~bus.Write & (sel != REG_NONE);
  assign pop      = rd_en & (sel == REG_FIFO);
  assign status_w = 32'({drop_q, ovf_q, fill});

  always_comb begin
    case (sel)
      REG_CFG:    rdata_d = cfg_q;
      REG_WIN:    rdata_d = win_rd;
      REG_STATUS: rdata_d = status_w;
      REG_FIFO:   rdata_d = fifo_empty ? 32'h0 : fifo_rdata;
      default:    rdata_d = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q  <= 32'h0000_00FF;
      for (int c = 0; c < NCLASS; c++) win_q[c] <= WIN_RST[c*32 +: 32];
      ovf_q  <= 1'b0;
      drop_q <= '0;
      dout_q <= '0;
      ack_q  <= 1'b0;
    end else begin
      ack_q  <= wr_en | rd_en;
      dout_q <= rd_en ? rdata_d : 32'h0;
      if (wr_en && sel == REG_CFG) cfg_q <= bus.DataIn;
      for (int c = 0; c < NCLASS; c++) begin
        if (wr_en && ofs == 8'(OFS_WIN0 + c)) win_q[c] <= bus.DataIn;
      end
      if (wr_en && sel == REG_STATUS && bus.DataIn[0]) begin
        ovf_q  <= 1'b0;
        drop_q <= '0;
      end else if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
    end
  end

  assign bus.DataOut = dout_q;
  assign bus.ack     = ack_q;

endmodule

// File: tb/tb_fine_time_classifier.sv
// Directed self-checking bench for fine_time_classifier (default parameters).
module tb_fine_time_classifier;

  localparam logic [7:0] A_CFG    = 8'd0;
  localparam logic [7:0] A_WIN0   = 8'd1;
  localparam logic [7:0] A_WIN1   = 8'd2;
  localparam logic [7:0] A_WIN2   = 8'd3;
  localparam logic [7:0] A_STATUS = 8'd4;
  localparam logic [7:0] A_FIFO   = 8'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [35:0] sample_in = '0;
  logic        sample_vld = 1'b0;
  logic [2:0]  class_hit;
  logic [4:0]  fine_time;
  logic        multi_hit, hit_vld;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] tb_cyc;
  logic [15:0] exp_ts;
  logic [31:0] exp_q [16];
  logic [31:0] rd_data;
  logic        rd_ack;

  fine_time_classifier_if bus_if ();

  fine_time_classifier dut (
    .clk        (clk),
    .rst        (rst),
    .sample_in  (sample_in),
    .sample_vld (sample_vld),
    .class_hit  (class_hit),
    .fine_time  (fine_time),
    .multi_hit  (multi_hit),
    .hit_vld    (hit_vld),
    .bus        (bus_if)
  );

  always #10 clk = ~clk;

  // Expected coarse timestamp: cycles since reset release, free-running 16 bit.
  always @(posedge clk) tb_cyc <= rst ? 16'd0 : tb_cyc + 16'd1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ent(input logic [15:0] ts, input logic mh,
                                      input logic [2:0] cls, input logic [4:0] ft);
    return {7'd0, ts, mh, cls, ft};
  endfunction

  task automatic bus_rd(input logic [7:0] a);
    bus_if.Address = a;
    bus_if.Read    = 1'b1;
    @(negedge clk);
    bus_if.Read    = 1'b0;
    bus_if.Address = '0;
    rd_data = bus_if.DataOut;
    rd_ack  = bus_if.ack;
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a,
                          input logic [31:0] exp, input logic exp_ack);
    bus_rd(a);
    check({tag, " data"}, rd_data, exp);
    check({tag, " ack"}, 32'(rd_ack), 32'(exp_ack));
  endtask

  task automatic bus_wr(input string tag, input logic [7:0] a, input logic [31:0] d);
    bus_if.Address = a;
    bus_if.DataIn  = d;
    bus_if.Write   = 1'b1;
    @(negedge clk);
    bus_if.Write   = 1'b0;
    bus_if.Address = '0;
    check({tag, " ack"}, 32'(bus_if.ack), 32'd1);
  endtask

  // Drive one snapshot and stop at the negedge where stage 2 is visible.
  task automatic hit(input logic [35:0] s, input logic v);
    sample_in  = s;
    sample_vld = v;
    exp_ts     = tb_cyc;
    @(negedge clk);
    sample_in  = '0;
    sample_vld = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic vld, input logic [4:0] ft,
                           input logic mh, input logic [2:0] cls);
    check({tag, " hit_vld"}, 32'(hit_vld), 32'(vld));
    check({tag, " class_hit"}, 32'(class_hit), 32'(cls));
    if (vld) begin
      check({tag, " fine_time"}, 32'(fine_time), 32'(ft));
      check({tag, " multi_hit"}, 32'(multi_hit), 32'(mh));
    end
  endtask

  initial begin
    bus_if.Address = '0;
    bus_if.DataIn  = '0;
    bus_if.Read    = 1'b0;
    bus_if.Write   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state and register defaults
    check_out("reset", 1'b0, 5'd0, 1'b0, 3'b000);
    check("reset fine_time", 32'(fine_time), 32'd0);
    check("reset multi_hit", 32'(multi_hit), 32'd0);
    check("reset DataOut", bus_if.DataOut, 32'd0);
    check("reset ack", 32'(bus_if.ack), 32'd0);
    rd_check("CFG rst", A_CFG, 32'h0000_00FF, 1'b1);
    rd_check("WIN0 rst", A_WIN0, 32'hFFFF_FFFF, 1'b1);
    rd_check("WIN1 rst", A_WIN1, 32'h0000_F000, 1'b1);
    rd_check("WIN2 rst", A_WIN2, 32'h0F00_0000, 1'b1);
    rd_check("STATUS rst", A_STATUS, 32'h0, 1'b1);
    rd_check("unmapped", 8'h20, 32'h0, 1'b0);

    // Single edge at k=5 (taps 6..8 set)
    hit(36'h0_0000_01C0, 1'b1);
    check_out("single", 1'b1, 5'd5, 1'b0, 3'b001);
    @(negedge clk);
    check_out("single end", 1'b0, 5'd0, 1'b0, 3'b000);
    rd_check("single fill", A_STATUS, 32'h1, 1'b1);
    rd_check("single entry", A_FIFO, ent(exp_ts, 1'b0, 3'b001, 5'd5), 1'b1);

    // Edges at k=2 and k=20, WIN0 narrowed to tap 20
    bus_wr("WIN0 wr", A_WIN0, 32'h0010_0000);
    hit(36'h0_00E0_0038, 1'b1);
    check_out("double", 1'b1, 5'd2, 1'b1, 3'b001);
    @(negedge clk);
    rd_check("double entry", A_FIFO, ent(exp_ts, 1'b1, 3'b001, 5'd2), 1'b1);

    // Edge at k=13 falls into WIN1 only
    hit(36'h0_0001_C000, 1'b1);
    check_out("win1", 1'b1, 5'd13, 1'b0, 3'b010);
    @(negedge clk);
    rd_check("win1 entry", A_FIFO, ent(exp_ts, 1'b0, 3'b010, 5'd13), 1'b1);

    // Snapshot without strobe is ignored
    hit(36'h0_0000_01C0, 1'b0);
    check_out("no vld", 1'b0, 5'd0, 1'b0, 3'b000);
    @(negedge clk);
    rd_check("no vld fill", A_STATUS, 32'h0, 1'b1);

    // All classes disabled: hit seen but nothing recorded
    bus_wr("CFG 0", A_CFG, 32'h0);
    hit(36'h0_0000_01C0, 1'b1);
    check_out("cfg0", 1'b1, 5'd5, 1'b0, 3'b000);
    @(negedge clk);
    rd_check("cfg0 fill", A_STATUS, 32'h0, 1'b1);

    // Record-all pushes unclassified hits
    bus_wr("CFG rec", A_CFG, 32'h8000_0000);
    hit(36'h0_0000_01C0, 1'b1);
    check_out("recall", 1'b1, 5'd5, 1'b0, 3'b000);
    @(negedge clk);
    rd_check("recall entry", A_FIFO, ent(exp_ts, 1'b0, 3'b000, 5'd5), 1'b1);

    // 18 back-to-back hits at k=1..18 into a 16-deep FIFO
    bus_wr("CFG all", A_CFG, 32'h8000_00FF);
    for (int i = 0; i < 19; i++) begin
      if (i < 18) begin
        sample_in  = 36'h7 << (i + 2);
        sample_vld = 1'b1;
        if (i < 16)
          exp_q[i] = ent(tb_cyc, 1'b0, ((i + 1) >= 12 && (i + 1) <= 15) ? 3'b010 : 3'b000,
                         5'(i + 1));
      end else begin
        sample_in  = '0;
        sample_vld = 1'b0;
      end
      @(negedge clk);
      if (i >= 1) begin
        check("b2b hit_vld", 32'(hit_vld), 32'd1);
        check("b2b fine_time", 32'(fine_time), 32'(i));
      end
    end
    sample_in  = '0;
    sample_vld = 1'b0;
    repeat (2) @(negedge clk);
    rd_check("full status", A_STATUS, 32'h0000_00B0, 1'b1);
    bus_wr("STATUS clr", A_STATUS, 32'h1);
    rd_check("cleared status", A_STATUS, 32'h0000_0010, 1'b1);

    // Read and Write together on FIFO: acked, no data, no pop
    bus_if.Address = A_FIFO;
    bus_if.Read    = 1'b1;
    bus_if.Write   = 1'b1;
    @(negedge clk);
    bus_if.Read    = 1'b0;
    bus_if.Write   = 1'b0;
    check("rw ack", 32'(bus_if.ack), 32'd1);
    check("rw data", bus_if.DataOut, 32'h0);
    rd_check("rw no pop", A_STATUS, 32'h0000_0010, 1'b1);

    for (int i = 0; i < 16; i++) begin
      rd_check("drain entry", A_FIFO, exp_q[i], 1'b1);
    end
    rd_check("empty pop", A_FIFO, 32'h0, 1'b1);
    rd_check("empty status", A_STATUS, 32'h0, 1'b1);

    // Reset one cycle after a hit flushes the pipeline
    bus_wr("CFG pre-rst", A_CFG, 32'h0000_0013);
    sample_in  = 36'h0_0000_01C0;
    sample_vld = 1'b1;
    @(negedge clk);
    sample_in  = '0;
    sample_vld = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_out("post rst", 1'b0, 5'd0, 1'b0, 3'b000);
      @(negedge clk);
    end
    rd_check("post rst status", A_STATUS, 32'h0, 1'b1);
    rd_check("post rst CFG", A_CFG, 32'h0000_00FF, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fine_time_classifier.md
Name: fine_time_classifier

Overview:
- Parametrised successor of the per-channel fine-time hit decoder.
- Input: thermometer snapshot of the TDC delay taps, already moved into the 50 MHz domain.
- Functions:
  - finds leading edges and encodes the lowest edge as fine time;
  - classifies the hit against NCLASS programmable tap windows (electron, pion, muon, ...);
  - timestamps each recorded hit with a coarse counter and buffers it in a readable hit FIFO.
- All control and status is reachable over the local bus.

Parameters:
- TAPS, 32, decoded tap count; 8..32.
- NCLASS, 3, number of particle classes; 1..6.
- BASE_ADDR, 8'h00, first local-bus address of this block.
- FIFO_DEPTH, 16, hit FIFO entries; power of two.
- WIN_RST, {32'h0F000000,32'h0000F000,32'hFFFFFFFF}, packed NCLASS x 32 window reset values; class 0 is in the LSBs.

Ports:
- clk  in  1  50 MHz clock.
- rst  in  1  synchronous, active-high reset.
- sample_in  in  TAPS+4  thermometer snapshot; bit 0 is the earliest tap.
- sample_vld  in  1  one-cycle strobe; the snapshot holds a new hit.
- class_hit  out  NCLASS  one-cycle pulse per matched, enabled class.
- fine_time  out  FT_W=clog2(TAPS)  index of the lowest edge; valid while hit_vld=1.
- multi_hit  out  1  more than one edge found; valid while hit_vld=1.
- hit_vld  out  1  one-cycle pulse; at least one edge found.
- Address  in  8  local-bus address.
- DataIn  in  32  local-bus write data.
- DataOut  out  32  local-bus read data; 0 when not addressed.
- Read  in  1  one-cycle read strobe.
- Write  in  1  one-cycle write strobe.
- ack  out  1  one-cycle acknowledge.

Behaviour:
- Reset: all outputs 0; FIFO empty; coarse counter 0; overflow flag 0; drop count 0; CFG=32'h0000_00FF; WIN[c]=WIN_RST[c].
- Stage 1 (cycle after sample_vld):
  - edge[k] = s[k+1]&s[k+2]&s[k+3]&~s[k+4] for k=0..TAPS-1;
  - edge is all-zero when sample_vld=0;
  - coarse_ts (16-bit, free-running, wraps 0xFFFF->0) is captured with edge.
- Stage 2 (2 cycles after sample_vld):
  - hit_vld = |edge;
  - fine_time = index of lowest set edge bit;
  - multi_hit = popcount(edge) > 1;
  - class_hit[c] = |(edge & WIN[c][TAPS-1:0]) & CFG[c].
  - Fully pipelined: back-to-back sample_vld produces back-to-back results.
- FIFO push:
  - Condition: at stage 2, when |class_hit, or when CFG[31] (record-all) and hit_vld.
  - Entry = {coarse_ts[15:0], multi_hit, class_hit, fine_time}, zero-extended to 32 bits.
- FIFO full:
  - A push is dropped, the sticky overflow flag is set, and the 8-bit drop count increments, saturating at 255.
  - Push and pop in the same cycle while full both succeed; no drop.
- Pop from an empty FIFO returns 0, leaves state unchanged, and still acks.
- Register map (offset from BASE_ADDR):
  - 0: CFG, RW.
  - 1..NCLASS: WIN[c-1], RW.
  - NCLASS+1: STATUS, RO: {drop_cnt[7:0], overflow, fill_count}. A write with DataIn[0]=1 clears overflow and drop_cnt.
  - NCLASS+2: FIFO, RO; a read pops.
- Bus timing:
  - DataOut and ack are registered and valid the cycle after Read/Write; DataOut is 0 otherwise.
  - Unmapped addresses: no ack, DataOut 0.
  - Read and Write together: Write wins, no pop.
- Reset mid-operation flushes the pipeline; no class_hit or hit_vld appears after rst.

Optional Feature:
- Macro: FINE_TIME_LOOSE_EDGE_EN.
- Defined: edge[k] = s[k+3]&~s[k+4], a relaxed pattern that tolerates short bubbles.
- Undefined: the strict 1110 pattern above. The register map is unchanged either way.

Decomposition:
- Package tdc_pkg holds:
  - register offset constants (OFS_CFG, OFS_WIN0, OFS_STATUS(n), OFS_FIFO(n));
  - entry field positions;
  - ft_width function (clog2);
  - CFG bit constants (CFG_RECORD_ALL=31).
- Sub-module hit_fifo: synchronous FIFO with fill_count, full/empty, and simultaneous push/pop.

Test Plan:
- Reset then read CFG and WIN0..WIN2 -> 0xFF, 0xFFFFFFFF, 0x0000F000, 0x0F000000, each acked one cycle later; STATUS reads 0.
- sample_in bits 6,7,8=1, bit 9=0, vld=1 -> two cycles later hit_vld=1, fine_time=5, multi_hit=0, class_hit=3'b001; FIFO holds one entry with fine_time 5 and the captured coarse_ts.
- Edges at k=2 and k=20 -> fine_time=2, multi_hit=1; WIN0 written 0x00100000 -> class_hit[0] still 1 (via k=20).
- Same pattern with sample_vld=0 -> no hit_vld, FIFO empty. With CFG=0 and CFG[31]=1 -> hit_vld=1, class_hit=0, entry still pushed.
- 18 hits, no pops -> fill_count=16, overflow=1, drop_cnt=2. Write STATUS 0x1 -> both cleared. 16 FIFO reads return entries in order; a 17th read returns 0.
- Hit at cycle 0, rst at cycle 1 -> no hit_vld, FIFO empty, CFG back to 0xFF.
